// File: rtl/matrix_row_div.sv
// rtl/matrix_row_div.sv - row-wise fixed-point matrix divider, one shared restoring divider (MATRIX_ROW_DIV_ROUND_EN enables rounding)
module matrix_row_div #(
    parameter int DW   = 16,
    parameter int FRAC = 13
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_START,
    input  logic [DW-1:0] I_MAT [0:15][0:15],
    input  logic [DW-1:0] I_VEC [0:15],
    output logic          O_BUSY,
    output logic          O_DONE,
    output logic [DW-1:0] O_MAT [0:15][0:15]
);

    localparam int QW = DW + FRAC;
    localparam int SW = $clog2(QW);
    localparam logic [QW:0]   POS_LIM = {{(QW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [QW:0]   NEG_LIM = POS_LIM + (QW+1)'(1);
    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_WRITE, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DW-1:0] mat_q [0:15][0:15];
    logic [DW-1:0] vec_q [0:15];
    logic [3:0]    row, col;
    logic [SW-1:0] step;
    logic          sign_q;
    logic          a_zero_q;
    logic [DW-1:0] div_q;
    logic [QW-1:0] quo_q;
    logic [DW-1:0] rem_q;

    logic [DW-1:0] cur_a, cur_d, abs_a, abs_d;
    logic [DW:0]   rem_sh;
    logic          rem_ge;
    logic [DW-1:0] rem_nxt;
    logic [QW:0]   q_ext;
    logic [DW-1:0] result;
`ifdef MATRIX_ROW_DIV_ROUND_EN
    logic          round_up;
`endif

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (I_START) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ITER;
            S_ITER:  if (step == SW'(QW-1)) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (row == 4'd15 && col == 4'd15) ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign O_BUSY = (state != S_IDLE);

    always_comb begin
        cur_a   = mat_q[row][col];
        cur_d   = vec_q[row];
        abs_a   = cur_a[DW-1] ? -cur_a : cur_a;
        abs_d   = cur_d[DW-1] ? -cur_d : cur_d;
        rem_sh  = {rem_q, quo_q[QW-1]};
        rem_ge  = (rem_sh >= {1'b0, div_q});
        rem_nxt = rem_ge ? DW'(rem_sh - {1'b0, div_q}) : rem_sh[DW-1:0];
`ifdef MATRIX_ROW_DIV_ROUND_EN
        round_up = (div_q != '0) && ({rem_q, 1'b0} >= {1'b0, div_q});
        q_ext    = {1'b0, quo_q} + (QW+1)'(round_up);
`else
        q_ext    = {1'b0, quo_q};
`endif
        // A zero divisor leaves an all-ones quotient, so it is resolved from the dividend alone.
        if (div_q == '0)
            result = a_zero_q ? '0 : (sign_q ? NEG_MIN : POS_MAX);
        else if (!sign_q)
            result = (q_ext > POS_LIM) ? POS_MAX : q_ext[DW-1:0];
        else
            result = (q_ext > NEG_LIM) ? NEG_MIN : -q_ext[DW-1:0];
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            for (int r = 0; r < 16; r++) begin
                vec_q[r] <= '0;
                for (int c = 0; c < 16; c++) begin
                    mat_q[r][c] <= '0;
                    O_MAT[r][c] <= '0;
                end
            end
            O_DONE   <= 1'b0;
            row      <= '0;
            col      <= '0;
            step     <= '0;
            sign_q   <= 1'b0;
            a_zero_q <= 1'b0;
            div_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
        end else begin
            O_DONE <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (I_START) begin
                        mat_q <= I_MAT;
                        vec_q <= I_VEC;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                S_LOAD: begin
                    sign_q   <= cur_a[DW-1] ^ cur_d[DW-1];
                    a_zero_q <= (cur_a == '0);
                    div_q    <= abs_d;
                    quo_q    <= {abs_a, {FRAC{1'b0}}};
                    rem_q    <= '0;
                    step     <= '0;
                end
                S_ITER: begin
                    // Dividend bits shift out the top while quotient bits fill in from the bottom.
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[QW-2:0], rem_ge};
                    step  <= step + SW'(1);
                end
                S_WRITE: begin
                    O_MAT[row][col] <= result;
                    col <= col + 4'd1;
                    if (col == 4'd15) row <= row + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
